// File: rtl/snake_step_controller.sv
// Snake game step controller: frame-paced head movement, PS/2 steering,
// optional growth and a serial self-collision scan over the body.
module snake_step_controller #(
  parameter int MAX_LEN         = 100,
  parameter int GRID_W          = 8,
  parameter int GRID_H          = 8,
  parameter int FRAMES_PER_STEP = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   screenEnd,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   grow,
  output logic [32*MAX_LEN-1:0]  x_values,
  output logic [32*MAX_LEN-1:0]  y_values,
  output logic [7:0]             snake_len,
  output logic                   game_done,
  output logic                   busy
);

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {S_WAIT, S_MOVE, S_CHECK, S_DONE} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t             r_state, w_state_nxt;
  dir_t               r_dir_cur, r_dir_pend;
  dir_t               w_key_dir, w_dir_ref, w_dir_rev;
  logic [FC_W-1:0]    r_frame;
  logic               r_step_pend, r_break, r_grow_pend;
  logic [7:0]         r_len, r_idx;
  logic signed [31:0] r_seg_x [MAX_LEN];
  logic signed [31:0] r_seg_y [MAX_LEN];
  logic signed [31:0] w_new_x, w_new_y, w_cmp_x, w_cmp_y;
  logic               w_tick, w_oob, w_hit, w_last, w_key_ok;

  assign w_tick = screenEnd && (r_frame == FC_W'(FRAMES_PER_STEP - 1));

  always_comb begin
    w_key_ok  = 1'b0;
    w_key_dir = D_RIGHT;
    if (rx_valid && !r_break && r_state != S_DONE) begin
      case (rx_data)
        8'h1D: begin w_key_ok = 1'b1; w_key_dir = D_UP;    end
        8'h1B: begin w_key_ok = 1'b1; w_key_dir = D_DOWN;  end
        8'h1C: begin w_key_ok = 1'b1; w_key_dir = D_LEFT;  end
        8'h23: begin w_key_ok = 1'b1; w_key_dir = D_RIGHT; end
        default: ;
      endcase
    end
    // A key landing in MOVE is judged against the direction being committed now
    w_dir_ref = (r_state == S_MOVE) ? r_dir_pend : r_dir_cur;
    case (w_dir_ref)
      D_UP:    w_dir_rev = D_DOWN;
      D_DOWN:  w_dir_rev = D_UP;
      D_LEFT:  w_dir_rev = D_RIGHT;
      default: w_dir_rev = D_LEFT;
    endcase
  end

  always_comb begin
    w_new_x = r_seg_x[0];
    w_new_y = r_seg_y[0];
    case (r_dir_pend)
      D_UP:    w_new_y = r_seg_y[0] - 32'sd1;
      D_DOWN:  w_new_y = r_seg_y[0] + 32'sd1;
      D_LEFT:  w_new_x = r_seg_x[0] - 32'sd1;
      default: w_new_x = r_seg_x[0] + 32'sd1;
    endcase
    w_oob = (w_new_x < 0) || (w_new_x >= GRID_W) || (w_new_y < 0) || (w_new_y >= GRID_H);
  end

  always_comb begin
    w_cmp_x = '0;
    w_cmp_y = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (8'(i) == r_idx) begin
        w_cmp_x = r_seg_x[i];
        w_cmp_y = r_seg_y[i];
      end
    end
    w_hit  = (w_cmp_x == r_seg_x[0]) && (w_cmp_y == r_seg_y[0]);
    w_last = (r_idx == r_len - 8'd1);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (r_step_pend || w_tick) w_state_nxt = S_MOVE;
      S_MOVE:  w_state_nxt = w_oob ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (w_hit)       w_state_nxt = S_DONE;
        else if (w_last) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame     <= '0;
      r_step_pend <= 1'b0;
      r_break     <= 1'b0;
      r_grow_pend <= 1'b0;
      r_dir_cur   <= D_RIGHT;
      r_dir_pend  <= D_RIGHT;
      r_len       <= 8'd3;
      r_idx       <= 8'd1;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i < 3) ? 32'(3 - i) : '0;
        r_seg_y[i] <= (i < 3) ? 32'sd3 : '0;
      end
    end else if (r_state != S_DONE) begin
      if (screenEnd) r_frame <= w_tick ? '0 : r_frame + FC_W'(1);
      // A step boundary reached while busy is held until WAIT can act on it
      if (r_state == S_WAIT) r_step_pend <= r_step_pend && w_tick;
      else if (w_tick)       r_step_pend <= 1'b1;
      if (rx_valid) begin
        if (r_break)               r_break <= 1'b0;
        else if (rx_data == 8'hF0) r_break <= 1'b1;
      end
      if (w_key_ok && w_key_dir != w_dir_rev) r_dir_pend <= w_key_dir;
      if (grow) r_grow_pend <= 1'b1;
      if (r_state == S_MOVE) begin
        r_dir_cur <= r_dir_pend;
        r_idx     <= 8'd1;
        if (!w_oob) begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            r_seg_x[i] <= r_seg_x[i-1];
            r_seg_y[i] <= r_seg_y[i-1];
          end
          r_seg_x[0] <= w_new_x;
          r_seg_y[0] <= w_new_y;
          if (r_grow_pend) begin
            if (r_len < 8'(MAX_LEN)) r_len <= r_len + 8'd1;
            r_grow_pend <= grow;
          end
        end
      end
      if (r_state == S_CHECK) r_idx <= r_idx + 8'd1;
    end
  end

  always_comb begin
    x_values = '0;
    y_values = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (8'(i) < r_len) begin
        x_values[32*i +: 32] = r_seg_x[i];
        y_values[32*i +: 32] = r_seg_y[i];
      end
    end
  end

  assign snake_len = r_len;
  assign game_done = (r_state == S_DONE);
  assign busy      = (r_state == S_MOVE) || (r_state == S_CHECK);

endmodule

// File: tb/tb_snake_step_controller.sv
// Scoreboard bench for snake_step_controller: each step pushes its expected
// outcome; a monitor pops and compares when the step ends or the game ends.
module tb_snake_step_controller;

  localparam int MAX_LEN = 5;
  localparam int GW      = 8;
  localparam int GH      = 8;
  localparam int FPS     = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  screenEnd = 1'b0;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  grow = 1'b0;
  logic [32*MAX_LEN-1:0] x_values, y_values;
  logic [7:0]            snake_len;
  logic                  game_done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int tag; int hx; int hy; int len; int done; int bcyc; int k; int kx; int ky;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic prev_busy = 1'b0, prev_done = 1'b0;
  int   bcnt = 0;

  snake_step_controller #(
    .MAX_LEN(MAX_LEN), .GRID_W(GW), .GRID_H(GH), .FRAMES_PER_STEP(FPS)
  ) dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .rx_valid(rx_valid),
    .rx_data(rx_data), .grow(grow), .x_values(x_values), .y_values(y_values),
    .snake_len(snake_len), .game_done(game_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int sx(int i);
    return int'(x_values[32*i +: 32]);
  endfunction
  function automatic int sy(int i);
    return int'(y_values[32*i +: 32]);
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if ((prev_busy && !busy) || (!prev_done && game_done)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_step: got a step end, required none");
        end else begin
          e = q.pop_front();
          check($sformatf("step%0d.head_x", e.tag), sx(0), e.hx);
          check($sformatf("step%0d.head_y", e.tag), sy(0), e.hy);
          check($sformatf("step%0d.len", e.tag), int'(snake_len), e.len);
          check($sformatf("step%0d.done", e.tag), int'(game_done), e.done);
          check($sformatf("step%0d.busy_cycles", e.tag), bcnt, e.bcyc);
          check($sformatf("step%0d.seg%0d_x", e.tag, e.k), sx(e.k), e.kx);
          check($sformatf("step%0d.seg%0d_y", e.tag, e.k), sy(e.k), e.ky);
        end
        bcnt = 0;
      end
      prev_busy = busy;
      prev_done = game_done;
    end
  end

  task automatic expect_step(int tag, int hx, int hy, int len, int done, int bcyc,
                             int k, int kx, int ky);
    exp_t x;
    x.tag = tag; x.hx = hx; x.hy = hy; x.len = len; x.done = done;
    x.bcyc = bcyc; x.k = k; x.kx = kx; x.ky = ky;
    q.push_back(x);
  endtask

  task automatic pulse_se();
    @(negedge clk); screenEnd = 1'b1;
    @(negedge clk); screenEnd = 1'b0;
  endtask

  task automatic send_rx(logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic pulse_grow();
    @(negedge clk); grow = 1'b1;
    @(negedge clk); grow = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout.pending_steps", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_step();
    pulse_se();
    pulse_se();
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic check_reset_state(string p);
    check({p, ".head_x"}, sx(0), 3);
    check({p, ".head_y"}, sy(0), 3);
    check({p, ".seg1_x"}, sx(1), 2);
    check({p, ".seg2_x"}, sx(2), 1);
    check({p, ".seg2_y"}, sy(2), 3);
    check({p, ".seg3_x"}, sx(3), 0);
    check({p, ".len"}, int'(snake_len), 3);
    check({p, ".done"}, int'(game_done), 0);
    check({p, ".busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Plain step; seg3 holds a shifted value but lies beyond snake_len
    expect_step(1, 4, 3, 3, 0, 3, 3, 0, 0);
    run_step();

    // One frame pulse lands during MOVE/CHECK and must still count
    expect_step(2, 5, 3, 3, 0, 3, 1, 4, 3);
    expect_step(3, 6, 3, 3, 0, 3, 1, 5, 3);
    pulse_se();
    pulse_se();
    pulse_se();
    n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    pulse_se();
    wait_drain();

    // Reverse key ignored, then UP
    do_reset();
    send_rx(8'h1C);
    expect_step(4, 4, 3, 3, 0, 3, 1, 3, 3);
    run_step();
    send_rx(8'h1D);
    expect_step(5, 4, 2, 3, 0, 3, 1, 4, 3);
    run_step();

    // Break code swallows the following byte
    do_reset();
    send_rx(8'hF0);
    send_rx(8'h1D);
    expect_step(6, 4, 3, 3, 0, 3, 1, 3, 3);
    run_step();
    send_rx(8'h1D);
    expect_step(7, 4, 2, 3, 0, 3, 1, 4, 3);
    run_step();

    // Run off the right edge
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      expect_step(7 + k, 3 + k, 3, 3, 0, 3, 1, 2 + k, 3);
      run_step();
    end
    expect_step(12, 7, 3, 3, 1, 1, 1, 6, 3);
    run_step();
    send_rx(8'h1D);
    pulse_grow();
    repeat (4) pulse_se();
    check("done_hold.head_x", sx(0), 7);
    check("done_hold.head_y", sy(0), 3);
    check("done_hold.seg1_x", sx(1), 6);
    check("done_hold.len", int'(snake_len), 3);
    check("done_hold.done", int'(game_done), 1);
    check("done_hold.busy", int'(busy), 0);

    // Grow to MAX_LEN, saturate, then turn into the body
    do_reset();
    pulse_grow();
    expect_step(13, 4, 3, 4, 0, 4, 3, 1, 3);
    run_step();
    pulse_grow();
    expect_step(14, 5, 3, 5, 0, 5, 4, 1, 3);
    run_step();
    pulse_grow();
    send_rx(8'h1B);
    expect_step(15, 5, 4, 5, 0, 5, 4, 2, 3);
    run_step();
    send_rx(8'h1C);
    expect_step(16, 4, 4, 5, 0, 5, 1, 5, 4);
    run_step();
    send_rx(8'h1D);
    expect_step(17, 4, 3, 5, 1, 5, 4, 4, 3);
    run_step();

    do_reset();
    check_reset_state("reset_from_done");

    // Asynchronous reset while CHECK is scanning
    pulse_se();
    pulse_se();
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check("midcheck.busy_before", int'(busy), 1);
    check("midcheck.head_x_before", sx(0), 4);
    reset = 1'b1;
    #1;
    check_reset_state("midcheck_reset");
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("leftover_expectations", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
